// File: rtl/demux_frame_dispatcher.sv
// Serialises a parallel word MSB-first onto the 1-to-4 demux data line, with per-bit framing strobes.
// Optional DEMUX_DISPATCH_PARITY_EN appends an even-parity bit after the data bits.
module demux_frame_dispatcher #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic [1:0]        sel,
    output logic              din,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

`ifdef DEMUX_DISPATCH_PARITY_EN
    localparam int unsigned LastIdx = DATA_W;
`else
    localparam int unsigned LastIdx = DATA_W - 1;
`endif

    // Index of the final bit of a frame (data bits, plus parity when enabled).
    localparam logic [CntW-1:0] LastCnt = CntW'(LastIdx);

    generate
        if (DATA_W < 2 || DATA_W > 32) begin : g_bad_width
            $error("demux_frame_dispatcher: DATA_W must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_nxt;
    logic              next_bit;

`ifdef DEMUX_DISPATCH_PARITY_EN
    localparam logic [CntW-1:0] DataCnt = CntW'(DATA_W);
    logic parity_q;
`endif

    assign in_ready = (state_q == StIdle) && !rst;
    assign cnt_nxt  = cnt_q + 1'b1;

    // shreg rotates, so bit DATA_W-2 is always the next data bit to present.
    always_comb begin
        next_bit = shreg_q[DATA_W-2];
`ifdef DEMUX_DISPATCH_PARITY_EN
        if (cnt_nxt == DataCnt) begin
            next_bit = parity_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sel         <= 2'd0;
            din         <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
`ifdef DEMUX_DISPATCH_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // The first bit goes out on the accept edge itself.
                        state_q     <= StShift;
                        shreg_q     <= in_data;
                        cnt_q       <= '0;
                        sel         <= in_dest;
                        din         <= in_data[DATA_W-1];
                        bit_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        frame_end   <= 1'b0;
                        busy        <= 1'b1;
`ifdef DEMUX_DISPATCH_PARITY_EN
                        parity_q    <= ^in_data;
`endif
                    end
                end
                StShift: begin
                    frame_start <= 1'b0;
                    if (cnt_q == LastCnt) begin
                        state_q   <= StGap;
                        din       <= 1'b0;
                        bit_valid <= 1'b0;
                        frame_end <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_nxt;
                        shreg_q   <= {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        din       <= next_bit;
                        frame_end <= (cnt_nxt == LastCnt);
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_frame_dispatcher.sv
// Bench for demux_frame_dispatcher: directed and random frames against a per-cycle frame model.
module tb_demux_frame_dispatcher;

`ifdef DEMUX_DISPATCH_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic [1:0] sel;
    logic       din;
    logic       bit_valid;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    int tests;
    int fails;

    demux_frame_dispatcher #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .sel        (sel),
        .din        (din),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Present a word at a negedge; the following posedge is the accept edge.
    task automatic start(input logic [7:0] d, input logic [1:0] dest);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dest;
        chk("ready_before_accept", 0, in_ready, 1'b1);
    endtask

    // Check cycles 1..FL+2 of a frame; in cycle 1 drive the next source request.
    task automatic body(input logic [7:0] d, input logic [1:0] dest, input logic nv,
                        input logic [7:0] nd, input logic [1:0] ndest);
        logic exp_din;
        for (int c = 1; c <= FL + 1; c++) begin
            @(negedge clk);
            if (c <= 8)       exp_din = d[8-c];
            else if (c == FL) exp_din = ^d;
            else              exp_din = 1'b0;
            chk("sel", c, sel, dest);
            chk("din", c, din, exp_din);
            chk("bit_valid", c, bit_valid, (c <= FL));
            chk("frame_start", c, frame_start, (c == 1));
            chk("frame_end", c, frame_end, (c == FL));
            chk("busy", c, busy, 1'b1);
            chk("ready_busy", c, in_ready, 1'b0);
            if (c == 1) begin
                in_valid = nv;
                in_data  = nd;
                in_dest  = ndest;
            end
        end
        @(negedge clk);
        chk("ready_after", FL + 2, in_ready, 1'b1);
        chk("busy_after", FL + 2, busy, 1'b0);
        chk("bit_valid_after", FL + 2, bit_valid, 1'b0);
        chk("sel_hold", FL + 2, sel, dest);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rdst;
        int         gap;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_dest  = 2'd2;

        // Reset held with a pending request.
        repeat (3) begin
            @(negedge clk);
            chk("rst_sel", 0, sel, 2'd0);
            chk("rst_din", 0, din, 1'b0);
            chk("rst_bit_valid", 0, bit_valid, 1'b0);
            chk("rst_strobes", 0, {frame_start, frame_end}, 2'b00);
            chk("rst_busy", 0, busy, 1'b0);
            chk("rst_ready", 0, in_ready, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("release_ready", 0, in_ready, 1'b1);
        chk("release_busy", 0, busy, 1'b0);
        in_valid = 1'b0;

        // Single frame, then held request that must wait for the first frame to finish.
        start(8'hA5, 2'd2);
        body(8'hA5, 2'd2, 1'b1, 8'h3C, 2'd1);
        body(8'h3C, 2'd1, 1'b0, 8'h00, 2'd0);

        // All-zero and all-one words.
        start(8'h00, 2'd3);
        body(8'h00, 2'd3, 1'b0, 8'h00, 2'd0);
        start(8'hFF, 2'd3);
        body(8'hFF, 2'd3, 1'b0, 8'h00, 2'd0);

        // Parity-relevant words (parity 1, then 0).
        start(8'h07, 2'd0);
        body(8'h07, 2'd0, 1'b0, 8'h00, 2'd0);
        start(8'h03, 2'd1);
        body(8'h03, 2'd1, 1'b0, 8'h00, 2'd0);

        // Reset in the middle of an 8'hFF frame.
        start(8'hFF, 2'd2);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("mid_din", c, din, 1'b1);
            if (c == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_din", 4, din, 1'b0);
        chk("mid_rst_bit_valid", 4, bit_valid, 1'b0);
        chk("mid_rst_sel", 4, sel, 2'd0);
        chk("mid_rst_busy", 4, busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_release_ready", 0, in_ready, 1'b1);
        for (int c = 1; c <= FL + 2; c++) begin
            @(negedge clk);
            chk("mid_no_frame_end", c, frame_end, 1'b0);
            chk("mid_no_bit_valid", c, bit_valid, 1'b0);
        end

        // Random words, destinations and idle gaps.
        for (int n = 0; n < 20; n++) begin
            rd   = 8'($urandom);
            rdst = 2'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            start(rd, rdst);
            body(rd, rdst, 1'b0, 8'h00, 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_frame_dispatcher.md
Name: demux_frame_dispatcher

Overview:
- Upstream feeder for the 1-to-4 demultiplexer. Accepts a parallel data word plus a 2-bit destination over a valid/ready handshake.
- Drives the demux select with the destination and serialises the word MSB-first onto the demux data input, one bit per clock.
- Adds per-bit qualifier and frame-delimit strobes so the downstream per-channel collectors can frame the bits.

Parameters:
- DATA_W, 8, width of the data word in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  source presents in_data/in_dest
- in_ready  output  1  dispatcher can accept a word this cycle
- in_data  input  DATA_W  word to serialise
- in_dest  input  2  destination channel, 0..3
- sel  output  2  demux select
- din  output  1  serial data bit to demux
- bit_valid  output  1  din carries a valid frame bit this cycle
- frame_start  output  1  high on first bit of frame
- frame_end  output  1  high on last bit of frame
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: sel=0, din=0, bit_valid=0, frame_start=0, frame_end=0, busy=0. State=IDLE, shift register=0, counter=0.
- FSM states: IDLE, SHIFT, GAP. in_ready = (state==IDLE) combinationally; no dependency on in_valid.
- Accept:
  - Occurs when in_valid && in_ready at a clock edge, called cycle 0.
  - On that edge: shreg <= in_data, sel <= in_dest, counter <= 0, state -> SHIFT.
- SHIFT:
  - All outputs are registered. Bit k (k=0 is the MSB) is presented in cycle k+1 after accept.
  - din=shreg[DATA_W-1], bit_valid=1; shreg shifts left by one each cycle.
  - frame_start=1 only in cycle 1. frame_end=1 only in the last bit cycle (cycle DATA_W).
  - Counter width is clog2(DATA_W+1). After the last bit, state -> GAP.
- GAP: exactly one cycle (cycle DATA_W+1) with bit_valid=0, din=0, in_ready=0; then state -> IDLE.
- Throughput: in_ready is high again in cycle DATA_W+2, so the minimum frame period is DATA_W+2 cycles.
- din is forced to 0 whenever bit_valid=0, so demux outputs idle low.
- sel holds its last destination from one accept until the next accept; it never changes mid-frame.
- in_valid while busy:
  - Ignored. in_data/in_dest changes are not sampled.
  - The source must hold the word until in_ready.
- Back-to-back: if in_valid is held high, the next word is accepted on the first IDLE cycle (cycle DATA_W+2 relative to the previous accept).
- Reset mid-frame: all outputs immediately go to their reset values and the partial frame is dropped. After rst deasserts, in_ready=1 in the first cycle.
- in_dest outside 0..3 cannot occur (2-bit).

Optional Feature:
- Macro: DEMUX_DISPATCH_PARITY_EN.
- Defined:
  - After the DATA_W data bits, one extra bit is sent: even parity (XOR of all in_data bits) with bit_valid=1.
  - frame_end moves to the parity cycle (cycle DATA_W+1). GAP is cycle DATA_W+2; in_ready returns in cycle DATA_W+3.
- Not defined: no parity bit; timing exactly as in Behaviour.

Test Plan:
- Reset: assert rst with in_valid=1 -> all outputs 0 and in_ready=0 while rst is high. After release -> in_ready=1, busy=0.
- Single frame, DATA_W=8, in_data=8'hA5, in_dest=2:
  - sel=2 from cycle 1.
  - din=1,0,1,0,0,1,0,1 in cycles 1-8 with bit_valid=1.
  - frame_start only in cycle 1, frame_end only in cycle 8.
  - Cycle 9: bit_valid=0, din=0. in_ready=1 in cycle 10.
- Held in_valid with a second word 8'h3C, dest 1, driven during the busy period, then held:
  - Not accepted until cycle 10.
  - sel stays 2 through cycle 9 and changes to 1 in cycle 11.
  - Second frame din=0,0,1,1,1,1,0,0.
- Reset mid-frame: rst pulsed during cycle 4 of an 8'hFF frame -> din=0, bit_valid=0, sel=0 immediately; in_ready=1 after release; no frame_end seen.
- Boundary: in_data=8'h00, dest 3 -> eight bit_valid cycles with din=0 and sel=3. Repeat with 8'hFF -> din=1 for eight cycles.
- With DEMUX_DISPATCH_PARITY_EN, in_data=8'h07:
  - Parity bit din=1 in cycle 9 with frame_end=1.
  - in_ready returns in cycle 11.
  - With 8'h03, parity bit is 0.
